// File: rtl/dpbram_modport.sv
// dpbram_modport: 8-bit programmable delay line on a dual-port RAM.
// Port A streams samples through a circular buffer. Port B is a pipelined
// Wishbone slave with direct RAM access and control/status registers.
module dpbram_modport #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DELAY = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    data_in,
    input  logic          in_valid,
    output logic [7:0]    data_out,
    output logic          out_valid,
    input  logic          wb_cyc,
    input  logic          wb_stb,
    input  logic          wb_we,
    input  logic [AW:0]   wb_addr,
    input  logic [7:0]    wb_data_i,
    output logic [7:0]    wb_data_o,
    output logic          wb_ack,
    output logic          wb_stall
);

    localparam int unsigned DEPTH    = 2 ** AW;
    localparam logic [7:0]  ID_VALUE = 8'hA5;

    typedef enum logic [1:0] {
        REG_DELAY = 2'd0,
        REG_FILL  = 2'd1,
        REG_WRPTR = 2'd2,
        REG_ID    = 2'd3
    } reg_idx_t;

    // Resize a bus byte to a pointer-width value (zero-extend or truncate).
    function automatic logic [AW-1:0] byte_to_aw(input logic [7:0] b);
        logic [AW+7:0] tmp;
        tmp = {{AW{1'b0}}, b};
        return tmp[AW-1:0];
    endfunction

    // Resize a pointer-width value to a bus byte (zero-extend or truncate).
    function automatic logic [7:0] aw_to_byte(input logic [AW-1:0] v);
        logic [AW+7:0] tmp;
        tmp = {8'h00, v};
        return tmp[7:0];
    endfunction

    logic [7:0]    mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] delay;
    logic [AW-1:0] fill;
    logic [AW-1:0] rd_addr;

    logic          wb_txn;
    logic          wb_ram_we;
    logic          wb_reg_we;
    logic [AW-1:0] wb_ram_addr;
    logic [AW-1:0] wb_wdata_aw;
    reg_idx_t      reg_idx;
    logic [7:0]    reg_rdata;
    logic          stream_collide;

    assign wb_stall       = 1'b0;
    assign wb_txn         = wb_cyc & wb_stb;
    assign wb_ram_addr    = wb_addr[AW-1:0];
    assign wb_ram_we      = wb_txn & wb_we & ~wb_addr[AW];
    assign wb_reg_we      = wb_txn & wb_we &  wb_addr[AW];
    assign reg_idx        = reg_idx_t'(wb_addr[1:0]);
    assign wb_wdata_aw    = byte_to_aw(wb_data_i);
    assign rd_addr        = wr_ptr - delay;
    assign stream_collide = in_valid & (wb_ram_addr == wr_ptr);

    // Register-space read mux; all values zero-extended to a byte.
    always_comb begin
        reg_rdata = '0;
        unique case (reg_idx)
            REG_DELAY: reg_rdata = aw_to_byte(delay);
            REG_FILL:  reg_rdata = aw_to_byte(fill);
            REG_WRPTR: reg_rdata = aw_to_byte(wr_ptr);
            REG_ID:    reg_rdata = ID_VALUE;
            default:   reg_rdata = '0;
        endcase
    end

    // RAM write ports; the stream write wins an address collision with Wishbone.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem[wr_ptr] <= data_in;
        end
        if (wb_ram_we && !stream_collide) begin
            mem[wb_ram_addr] <= wb_data_i;
        end
    end

    // Stream pointer/fill tracking, delayed output, and Wishbone response path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            fill      <= '0;
            delay     <= AW'(DELAY);
            data_out  <= '0;
            out_valid <= 1'b0;
            wb_ack    <= 1'b0;
            wb_data_o <= '0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                wr_ptr   <= wr_ptr + AW'(1);
                data_out <= mem[rd_addr];
                if (fill == delay) begin
                    out_valid <= 1'b1;
                end else begin
                    fill <= fill + AW'(1);
                end
            end

            // A delay write restarts the fill count, overriding any stream increment.
            if (wb_reg_we && (reg_idx == REG_DELAY)) begin
                delay <= (wb_wdata_aw == '0) ? AW'(1) : wb_wdata_aw;
                fill  <= '0;
            end

            wb_ack <= wb_txn;
            if (wb_txn && !wb_we) begin
                wb_data_o <= wb_addr[AW] ? reg_rdata : mem[wb_ram_addr];
            end
        end
    end

endmodule

// File: tb/tb_dpbram_modport.sv
// Directed self-checking bench for dpbram_modport (AW=8, DELAY=4).
module tb_dpbram_modport;

    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [7:0]    data_in;
    logic          in_valid;
    logic [7:0]    data_out;
    logic          out_valid;
    logic          wb_cyc;
    logic          wb_stb;
    logic          wb_we;
    logic [AW:0]   wb_addr;
    logic [7:0]    wb_data_i;
    logic [7:0]    wb_data_o;
    logic          wb_ack;
    logic          wb_stall;

    int errors = 0;
    int checks = 0;

    dpbram_modport #(.AW(AW), .DELAY(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .data_out  (data_out),
        .out_valid (out_valid),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data_i (wb_data_i),
        .wb_data_o (wb_data_o),
        .wb_ack    (wb_ack),
        .wb_stall  (wb_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d, output logic ov, output logic [7:0] dout);
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = d;
        @(posedge clk);
        #1;
        ov   = out_valid;
        dout = data_out;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = 8'h00;
    endtask

    task automatic wb_write(input logic [AW:0] a, input logic [7:0] d);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = a; wb_data_i = d;
        @(posedge clk);
        #1;
        check("wr_ack", wb_ack, 1);
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [AW:0] a, output logic [7:0] d);
        @(negedge clk);
        check("rd_ack_pre", wb_ack, 0);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = a;
        @(posedge clk);
        #1;
        check("rd_ack", wb_ack, 1);
        d = wb_data_o;
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(posedge clk);
        #1;
        check("rd_ack_drop", wb_ack, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       ov;
        logic [7:0] dout;
        logic [7:0] rd;

        reset_n = 1'b0; in_valid = 1'b0; data_in = '0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", data_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_wb_ack", wb_ack, 0);
        check("rst_wb_data_o", wb_data_o, 0);
        check("wb_stall", wb_stall, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Default delay of 4: samples 5..8 output samples 1..4
        for (int unsigned i = 1; i <= 8; i++) begin
            push(8'(i), ov, dout);
            if (i <= 4) begin
                check("dflt_nov", ov, 0);
            end else begin
                check("dflt_ov", ov, 1);
                check("dflt_data", dout, i - 4);
            end
        end
        idle();
        @(posedge clk);
        #1;
        check("pulse_drop", out_valid, 0);
        check("data_hold", data_out, 8'h04);

        // Delay reprogram to 2
        wb_write(9'h100, 8'h02);
        wb_read(9'h101, rd);
        check("fill_cleared", rd, 0);
        for (int unsigned i = 0; i < 5; i++) begin
            push(8'(8'h10 + i), ov, dout);
            if (i < 2) begin
                check("d2_nov", ov, 0);
            end else begin
                check("d2_ov", ov, 1);
                check("d2_data", dout, 8'h10 + i - 2);
            end
        end
        idle();
        wb_write(9'h100, 8'h00);
        wb_read(9'h100, rd);
        check("delay_zero_is_one", rd, 1);

        // Reset mid-stream with output and ack asserted
        for (int unsigned i = 0; i < 9; i++) begin
            push(8'(8'h40 + i), ov, dout);
        end
        @(negedge clk);
        in_valid = 1'b1; data_in = 8'h49;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 9'h100;
        @(posedge clk);
        #1;
        check("pre_rst_ov", out_valid, 1);
        check("pre_rst_data", data_out, 8'h48);
        check("pre_rst_ack", wb_ack, 1);
        check("pre_rst_wbdat", wb_data_o, 8'h01);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_data", data_out, 0);
        check("async_rst_ov", out_valid, 0);
        check("async_rst_ack", wb_ack, 0);
        check("async_rst_wbdat", wb_data_o, 0);
        @(negedge clk);
        in_valid = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        wb_read(9'h100, rd);
        check("rst_delay", rd, 4);
        wb_read(9'h102, rd);
        check("rst_wrptr", rd, 0);
        wb_read(9'h101, rd);
        check("rst_fill", rd, 0);

        // Wrap-around with delay 3 over 300 samples
        wb_write(9'h100, 8'h03);
        for (int unsigned i = 0; i < 300; i++) begin
            push(8'(i), ov, dout);
            if (i < 3) begin
                check("wrap_nov", ov, 0);
            end else begin
                check("wrap_ov", ov, 1);
                check("wrap_data", dout, (i - 3) & 8'hFF);
            end
        end
        idle();
        wb_read(9'h102, rd);
        check("wrap_wrptr", rd, 44);

        // Wishbone RAM write/read
        wb_write(9'h007, 8'h5A);
        wb_read(9'h007, rd);
        check("ram_rd", rd, 8'h5A);

        // Four back-to-back reads
        for (int unsigned i = 0; i < 4; i++) begin
            wb_write(9'(9'h020 + i), 8'(8'hC0 + i));
        end
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge clk);
            wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 9'(9'h020 + i);
            @(posedge clk);
            #1;
            check("b2b_ack", wb_ack, 1);
            check("b2b_data", wb_data_o, 8'hC0 + i);
        end
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_ack_drop", wb_ack, 0);

        // Collision: stream write and Wishbone write to RAM[wr_ptr=44]
        @(negedge clk);
        in_valid = 1'b1; data_in = 8'h33;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 9'h02C; wb_data_i = 8'hFF;
        @(posedge clk);
        #1;
        check("coll_ack", wb_ack, 1);
        @(negedge clk);
        in_valid = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_read(9'h02C, rd);
        check("coll_stream_wins", rd, 8'h33);
        wb_read(9'h103, rd);
        check("id_reg", rd, 8'hA5);

        // Writes to read-only registers are ignored
        wb_write(9'h102, 8'h77);
        wb_read(9'h102, rd);
        check("ro_wrptr", rd, 45);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
